// File: rtl/vrf_mp_banked.sv
// ---------------------------------------------------------------------------
// vrf_mp_banked
//  Multi-port vector register file for the vector coprocessor datapath.
//  VREGS registers of ELEMENTS x DATA_WIDTH bits, RD_PORTS registered read
//  ports (1-cycle latency) and two independent byte-enabled write ports:
//  A (vector unit) and B (element/load unit). After every reset a clear
//  sequencer sweeps the file to zero before it becomes usable.
//
// Ports
//  clk_i          clock, all state on the rising edge
//  reset          asynchronous, active-high reset
//  init_done_o    1 = clear sweep finished, file usable
//  rd_en_i        per-port read request
//  rd_addr_i      per-port register index (port p at [p*AW +: AW])
//  rd_data_o      per-port registered read data (port p at [p*RW +: RW],
//                 element k within it at [k*DATA_WIDTH +: DATA_WIDTH])
//  rd_valid_o     per-port 1-cycle pulse: rd_data_o for that port updated
//  wa_en_i        port A per-element write enable
//  wa_be_i        port A byte enables (element k byte b at [k*BPE+b])
//  wa_addr_i      port A register index
//  wa_data_i      port A write data
//  wb_*           same as port A, for port B
//  wr_conflict_o  registered pulse: A and B hit the same byte last cycle
//  dbg_state_o    sequencer state for debug: 0 = CLEAR, 1 = RUN
// ---------------------------------------------------------------------------
module vrf_mp_banked #(
    parameter int VREGS      = 32,
    parameter int ELEMENTS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int RD_PORTS   = 3,
    parameter int BYPASS     = 1,
    localparam int AW  = $clog2(VREGS),
    localparam int BPE = DATA_WIDTH / 8,
    localparam int RW  = ELEMENTS * DATA_WIDTH,
    localparam int NB  = ELEMENTS * BPE
) (
    input  logic                   clk_i,
    input  logic                   reset,
    output logic                   init_done_o,
    input  logic [RD_PORTS-1:0]    rd_en_i,
    input  logic [RD_PORTS*AW-1:0] rd_addr_i,
    output logic [RD_PORTS*RW-1:0] rd_data_o,
    output logic [RD_PORTS-1:0]    rd_valid_o,
    input  logic [ELEMENTS-1:0]    wa_en_i,
    input  logic [NB-1:0]          wa_be_i,
    input  logic [AW-1:0]          wa_addr_i,
    input  logic [RW-1:0]          wa_data_i,
    input  logic [ELEMENTS-1:0]    wb_en_i,
    input  logic [NB-1:0]          wb_be_i,
    input  logic [AW-1:0]          wb_addr_i,
    input  logic [RW-1:0]          wb_data_i,
    output logic                   wr_conflict_o,
    output logic                   dbg_state_o
);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t          state;
    logic [AW-1:0]   clr_cnt;
    logic [RW-1:0]   mem [VREGS];
    logic [NB-1:0]   a_mask;
    logic [NB-1:0]   b_mask;
    logic [RW-1:0]   rd_merge [RD_PORTS];

    assign dbg_state_o = (state == S_RUN);

    // Per-byte write masks: a byte is written only when its element enable
    // and its own byte enable are both set.
    for (genvar i = 0; i < NB; i++) begin : g_mask
        assign a_mask[i] = wa_en_i[i / BPE] & wa_be_i[i];
        assign b_mask[i] = wb_en_i[i / BPE] & wb_be_i[i];
    end

    // Storage has no reset: the clear sweep zeroes it. Port B is applied
    // before port A so that A's later assignment wins on a shared byte.
    always_ff @(posedge clk_i) begin
        if (state == S_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (b_mask[i]) mem[wb_addr_i][i*8 +: 8] <= wb_data_i[i*8 +: 8];
                if (a_mask[i]) mem[wa_addr_i][i*8 +: 8] <= wa_data_i[i*8 +: 8];
            end
        end
    end

    // Read data source per port. With bypass enabled, bytes being written
    // this cycle to the same register are forwarded (A over B); all other
    // bytes come from the array.
    always_comb begin
        for (int p = 0; p < RD_PORTS; p++) begin
            rd_merge[p] = mem[rd_addr_i[p*AW +: AW]];
            if (BYPASS != 0) begin
                for (int i = 0; i < NB; i++) begin
                    if (a_mask[i] && (wa_addr_i == rd_addr_i[p*AW +: AW]))
                        rd_merge[p][i*8 +: 8] = wa_data_i[i*8 +: 8];
                    else if (b_mask[i] && (wb_addr_i == rd_addr_i[p*AW +: AW]))
                        rd_merge[p][i*8 +: 8] = wb_data_i[i*8 +: 8];
                end
            end
        end
    end

    // Read handshake: rd_en_i[p] high in cycle N loads rd_data_o[p] at the
    // following edge and raises rd_valid_o[p] for exactly that one cycle;
    // with rd_en_i[p] low the data holds. There is no back-pressure.
    // Requests and writes are ignored until the sweep completes.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state         <= S_CLEAR;
            clr_cnt       <= '0;
            init_done_o   <= 1'b0;
            rd_data_o     <= '0;
            rd_valid_o    <= '0;
            wr_conflict_o <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    rd_valid_o    <= '0;
                    wr_conflict_o <= 1'b0;
                    clr_cnt       <= clr_cnt + 1'b1;
                    if (clr_cnt == AW'(VREGS - 1)) begin
                        state       <= S_RUN;
                        init_done_o <= 1'b1;
                    end
                end
                S_RUN: begin
                    wr_conflict_o <= (wa_addr_i == wb_addr_i) && (|(a_mask & b_mask));
                    for (int p = 0; p < RD_PORTS; p++) begin
                        rd_valid_o[p] <= rd_en_i[p];
                        if (rd_en_i[p]) rd_data_o[p*RW +: RW] <= rd_merge[p];
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

endmodule
